// File: rtl/out_mem_write_ctrl_if.sv
// Bundle between the pooling stage / output memory and the write sequencer.
// Widths must match the parameters of the out_mem_write_ctrl instance.
interface out_mem_write_ctrl_if #(
    parameter int VW            = 256,
    parameter int OUT_MEM_BANKS = 4,
    parameter int ADDR_WDT      = 8,
    parameter int WC_W          = 4
);
    logic                              frame_start;
    logic [ADDR_WDT-1:0]               base_addr;
    logic                              in_valid;
    logic                              in_sparse;
    logic [VW-1:0]                     in_vec;
    logic                              in_ready;
    logic [VW-1:0]                     mxpl_out_b;
    logic [WC_W-1:0]                   write_count;
    logic                              mem_ready;
    logic [OUT_MEM_BANKS-1:0]          mem_wen;
    logic [OUT_MEM_BANKS*ADDR_WDT-1:0] mem_addr;
    logic                              sparse_mode;
    logic                              busy;
    logic                              frame_done;
    logic                              err_overflow;

    modport master (
        output frame_start, base_addr, in_valid, in_sparse, in_vec, mem_ready,
        input  in_ready, mxpl_out_b, write_count, mem_wen, mem_addr,
               sparse_mode, busy, frame_done, err_overflow
    );

    modport slave (
        input  frame_start, base_addr, in_valid, in_sparse, in_vec, mem_ready,
        output in_ready, mxpl_out_b, write_count, mem_wen, mem_addr,
               sparse_mode, busy, frame_done, err_overflow
    );
endinterface

// File: rtl/out_mem_write_ctrl.sv
// Output-memory write sequencer: registers one pooled vector, then steps it
// out as dense (one bank per beat) or sparse (all banks per beat) writes.
module out_mem_write_ctrl #(
    parameter int N_S              = 4,
    parameter int N_C              = 4,
    parameter int N_B              = 4,
    parameter int OUT_MEM_DATA_WDT = 32,
    parameter int OUT_MEM_BANKS    = 4,
    parameter int ADDR_WDT         = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    out_mem_write_ctrl_if.slave  bus
);
    localparam int VW   = N_S * N_C * 16;
    localparam int D    = VW / OUT_MEM_DATA_WDT;
    localparam int S    = D / OUT_MEM_BANKS;
    localparam int WC_W = $clog2(N_B * S) + 1;
    localparam int BC_W = (N_B > 1) ? $clog2(N_B) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    generate
        if (D < 1 || S < 1 || D * OUT_MEM_DATA_WDT != VW || S * OUT_MEM_BANKS != D
            || WC_W < $clog2(D)) begin : g_bad_params
            $error("out_mem_write_ctrl: beat counts must be integers >= 1 and fit write_count");
        end
    endgenerate

    logic [0:0]                             r_state;
    logic [VW-1:0]                          r_vec;
    logic [WC_W-1:0]                        r_wc;
    logic                                   r_sparse;
    logic [OUT_MEM_BANKS-1:0][ADDR_WDT-1:0] r_ptr;
    logic [BC_W-1:0]                        r_batch;
    logic                                   r_done;
    logic                                   r_ovf;

    logic [OUT_MEM_BANKS-1:0]               w_wen;
    logic [31:0]                            w_bank_idx;
    logic                                   w_last;

    assign w_bank_idx = 32'(r_wc) % 32'(OUT_MEM_BANKS);
    assign w_last     = r_sparse ? (r_wc == WC_W'(S - 1)) : (r_wc == WC_W'(D - 1));

    // Gated by rst_n so an abandoned vector never issues another write.
    always_comb begin
        w_wen = '0;
        if (rst_n && r_state == ST_WRITE) begin
            for (int k = 0; k < OUT_MEM_BANKS; k++)
                w_wen[k] = r_sparse || (w_bank_idx == 32'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_wc     <= '0;
            r_sparse <= 1'b0;
            r_ptr    <= '0;
            r_batch  <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                // frame_start first so a same-cycle vector uses the new base
                if (bus.frame_start) begin
                    for (int k = 0; k < OUT_MEM_BANKS; k++) r_ptr[k] <= bus.base_addr;
                    r_batch <= '0;
                    r_wc    <= '0;
                    r_ovf   <= 1'b0;
                end
                if (bus.in_valid) begin
                    r_vec    <= bus.in_vec;
                    r_sparse <= bus.in_sparse;
                    r_wc     <= '0;
                    r_state  <= ST_WRITE;
                end
            end else if (bus.mem_ready) begin
                for (int k = 0; k < OUT_MEM_BANKS; k++) begin
                    if (w_wen[k]) begin
                        r_ptr[k] <= r_ptr[k] + ADDR_WDT'(1);
                        if (&r_ptr[k]) r_ovf <= 1'b1;
                    end
                end
                if (w_last) begin
                    r_wc    <= '0;
                    r_state <= ST_IDLE;
                    if (r_batch == BC_W'(N_B - 1)) begin
                        r_batch <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_batch <= r_batch + BC_W'(1);
                    end
                end else begin
                    r_wc <= r_wc + WC_W'(1);
                end
            end
        end
    end

    always_comb begin
        bus.mem_addr = '0;
        for (int k = 0; k < OUT_MEM_BANKS; k++)
            bus.mem_addr[k*ADDR_WDT +: ADDR_WDT] = r_ptr[k];
    end

    assign bus.in_ready     = rst_n && (r_state == ST_IDLE);
    assign bus.mxpl_out_b   = r_vec;
    assign bus.write_count  = r_wc;
    assign bus.mem_wen      = w_wen;
    assign bus.sparse_mode  = r_sparse;
    assign bus.busy         = (r_state == ST_WRITE);
    assign bus.frame_done   = r_done;
    assign bus.err_overflow = r_ovf;
endmodule

// File: tb/tb_out_mem_write_ctrl.sv
// Directed bench for out_mem_write_ctrl at default parameters (D=8, S=2, 4 banks).
module tb_out_mem_write_ctrl;
    localparam int VW = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    out_mem_write_ctrl_if #(.VW(VW), .OUT_MEM_BANKS(4), .ADDR_WDT(8), .WC_W(4)) bus ();

    out_mem_write_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] addr_of(input int k);
        return bus.mem_addr[k*8 +: 8];
    endfunction

    task automatic start_vec(input logic fs, input logic [7:0] base, input logic sp,
                             input logic [VW-1:0] v);
        bus.frame_start = fs;
        bus.base_addr   = base;
        bus.in_valid    = 1'b1;
        bus.in_sparse   = sp;
        bus.in_vec      = v;
        tick();
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b0;
    endtask

    logic [VW-1:0] v1, v2;
    int b, cyc, done_cnt;
    logic st2, st5;

    initial begin
        bus.frame_start = 1'b0;
        bus.base_addr   = '0;
        bus.in_valid    = 1'b0;
        bus.in_sparse   = 1'b0;
        bus.in_vec      = '0;
        bus.mem_ready   = 1'b1;
        rst_n           = 1'b0;
        v1 = {8{32'hDEAD_BEEF}};
        v2 = {4{64'h0123_4567_89AB_CDEF}};
        tick();
        tick();
        chk("ready_in_rst", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_wen", bus.mem_wen, 0);
        chk("rst_wc", bus.write_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_vec", bus.mxpl_out_b, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_flags", {bus.frame_done, bus.err_overflow, bus.sparse_mode}, 0);

        // Dense vector from base 0x10
        start_vec(1'b1, 8'h10, 1'b0, v1);
        for (int i = 0; i < 8; i++) begin
            chk("dense_wen", bus.mem_wen, 4'b1 << (i % 4));
            chk("dense_wc", bus.write_count, i);
            chk("dense_addr", addr_of(i % 4), 8'h10 + 8'(i / 4));
            chk("dense_busy", bus.busy, 1);
            tick();
        end
        chk("dense_ready_back", bus.in_ready, 1);
        chk("dense_wen_idle", bus.mem_wen, 0);
        chk("dense_vec", bus.mxpl_out_b, v1);
        chk("dense_mode", bus.sparse_mode, 0);
        chk("dense_ptr_end", bus.mem_addr, {4{8'h12}});

        // Sparse vector
        start_vec(1'b1, 8'h10, 1'b1, v2);
        for (int i = 0; i < 2; i++) begin
            chk("sparse_wen", bus.mem_wen, 4'hF);
            chk("sparse_wc", bus.write_count, i);
            chk("sparse_addr", bus.mem_addr, {4{8'h10 + 8'(i)}});
            tick();
        end
        chk("sparse_ready_back", bus.in_ready, 1);
        chk("sparse_mode", bus.sparse_mode, 1);
        chk("sparse_vec", bus.mxpl_out_b, v2);

        // Dense with stalls at beats 2 and 5
        start_vec(1'b1, 8'h20, 1'b0, v1);
        b = 0; cyc = 0; st2 = 1'b0; st5 = 1'b0;
        while (b < 8 && cyc < 20) begin
            cyc++;
            chk("stall_wc", bus.write_count, b);
            chk("stall_wen", bus.mem_wen, 4'b1 << (b % 4));
            chk("stall_addr", addr_of(b % 4), 8'h20 + 8'(b / 4));
            if (b == 2 && !st2) begin
                st2 = 1'b1; bus.mem_ready = 1'b0;
            end else if (b == 5 && !st5) begin
                st5 = 1'b1; bus.mem_ready = 1'b0;
            end else begin
                bus.mem_ready = 1'b1; b++;
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        chk("stall_cycles", cyc, 10);
        chk("stall_ready_back", bus.in_ready, 1);
        chk("stall_ptr_end", bus.mem_addr, {4{8'h22}});

        // Frame of 4 sparse vectors plus one more
        done_cnt = 0;
        for (int v = 0; v < 5; v++) begin
            start_vec(v == 0, 8'h40, 1'b1, v2 ^ VW'(v));
            for (int i = 0; i < 2; i++) begin
                done_cnt += int'(bus.frame_done);
                tick();
            end
            chk("frame_done_pulse", bus.frame_done, (v == 3));
            done_cnt += int'(bus.frame_done);
            if (v == 3) chk("frame_ptr_end", bus.mem_addr, {4{8'h48}});
        end
        tick();
        chk("frame_done_clear", bus.frame_done, 0);
        chk("frame_done_count", done_cnt, 1);
        chk("frame5_ptr", bus.mem_addr, {4{8'h4A}});

        // Overflow then restart with frame_start + in_valid together
        start_vec(1'b1, 8'hFF, 1'b1, v1);
        chk("ovf_addr_ff", bus.mem_addr, {4{8'hFF}});
        chk("ovf_not_yet", bus.err_overflow, 0);
        tick();
        chk("ovf_wrapped", bus.mem_addr, {4{8'h00}});
        chk("ovf_set", bus.err_overflow, 1);
        tick();
        chk("ovf_sticky", bus.err_overflow, 1);
        start_vec(1'b1, 8'h30, 1'b0, v2);
        chk("ovf_cleared", bus.err_overflow, 0);
        chk("restart_addr", addr_of(0), 8'h30);
        chk("restart_wen", bus.mem_wen, 4'b0001);
        repeat (8) tick();
        chk("restart_ready", bus.in_ready, 1);

        // Reset mid-WRITE at dense beat 3
        start_vec(1'b1, 8'h10, 1'b0, v1);
        repeat (3) tick();
        chk("mid_wc", bus.write_count, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", bus.mem_wen, 0);
        tick();
        chk("mid_rst_wc", bus.write_count, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_vec", bus.mxpl_out_b, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        chk("mid_rst_mode", bus.sparse_mode, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", bus.in_ready, 1);
        tick();
        chk("mid_rel_wen", bus.mem_wen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/out_mem_write_ctrl.md
# out_mem_write_ctrl

Sequencer for the output-memory write path. Accepts one max-pool result vector from the pooling stage through a valid/ready handshake and registers it. It then steps `write_count` through the beats of that vector to drive the dense and sparse output-memory muxes, and generates per-bank write enables and addresses for the `OUT_MEM_BANKS` output SRAM banks. It tracks batches within a frame and flags the end of each frame.

## Interface
Parameters:
- `N_S`, default 4: pooling slices.
- `N_C`, default 4: channels per slice. Vector width is `VW = N_S*N_C*16`.
- `N_B`, default 4: vectors (batches) per frame.
- `OUT_MEM_DATA_WDT`, default 32: bank word width.
- `OUT_MEM_BANKS`, default 4: number of banks.
- `ADDR_WDT`, default 8: per-bank address width.
- Derived: `D = VW/OUT_MEM_DATA_WDT` (dense beats), `S = D/OUT_MEM_BANKS` (sparse beats), `WC_W = $clog2(N_B*S)+1`.
- Elaboration error unless `D` and `S` are integers ≥1 and `WC_W ≥ $clog2(D)`.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `frame_start`, in, 1: starts a new frame. Loads `base_addr` and clears counters; honoured only in IDLE.
- `base_addr`, in, `ADDR_WDT`: start address applied to every bank at `frame_start`.
- `in_valid`, in, 1: producer has a vector.
- `in_sparse`, in, 1: selects mode. 1 = sparse (all banks written per beat), 0 = dense (one bank per beat).
- `in_vec`, in, `VW`: pooled vector.
- `in_ready`, out, 1: controller can accept a vector.
- `mxpl_out_b`, out, `VW`: registered vector. Feeds both mux data inputs.
- `write_count`, out, `WC_W`: beat index within the current vector. Feeds both mux selects.
- `mem_ready`, in, 1: memory side accepts the current beat.
- `mem_wen`, out, `OUT_MEM_BANKS`: per-bank write enable.
- `mem_addr`, out, `OUT_MEM_BANKS*ADDR_WDT`: per-bank address. Bank k occupies `[k*ADDR_WDT +: ADDR_WDT]`.
- `sparse_mode`, out, 1: latched mode. Selects the dense or sparse mux output at the memory.
- `busy`, out, 1: high in WRITE.
- `frame_done`, out, 1: one-cycle pulse after the last beat of the `N_B`-th vector.
- `err_overflow`, out, 1: sticky. Set when any bank pointer wraps from `2^ADDR_WDT-1` to 0.

## Operation
- States are IDLE and WRITE. Reset puts the block in IDLE.
- `in_ready = rst_n && state==IDLE`.
- **IDLE:**
  - If `frame_start` is high: all bank pointers load `base_addr`; `batch_cnt`, `write_count` and `err_overflow` clear.
  - If `in_valid && in_ready`: latch `in_vec` into `mxpl_out_b` and `in_sparse` into `sparse_mode`; clear `write_count`; go to WRITE.
  - When both events occur in the same cycle, `frame_start` applies first and the vector is written from the new base.
- **WRITE:**
  - Dense: `mem_wen` is one-hot at bank `write_count % OUT_MEM_BANKS`.
  - Sparse: `mem_wen` is all ones.
  - A beat completes when `mem_ready` is high. On completion, each enabled bank's pointer increments by 1 (wrapping modulo `2^ADDR_WDT` and setting `err_overflow` on wrap), and `write_count` increments.
  - On completion of the last beat (`write_count == D-1` dense, `S-1` sparse):
    - `write_count` returns to 0, the state returns to IDLE, and `batch_cnt` increments.
    - If `batch_cnt` was `N_B-1`, assert `frame_done` in the next cycle and clear `batch_cnt` to 0.
  - While `mem_ready` is low, `write_count`, the pointers and `mem_wen` hold.
- `frame_start` and `in_valid` are ignored in WRITE. `mxpl_out_b` and `sparse_mode` hold until the next acceptance.
- `mem_wen = 0` in IDLE.
- `write_count` upper bits above `$clog2(D)` are always 0.
- Reset values: `mxpl_out_b=0`, `write_count=0`, `sparse_mode=0`, `mem_wen=0`, all pointers 0, `busy=0`, `frame_done=0`, `err_overflow=0`, `batch_cnt=0`.
- A reset taken mid-WRITE abandons the vector: no further `mem_wen` is asserted and the state returns to IDLE.

## Timing
- Acceptance at cycle t. First `mem_wen` at t+1 (registered state; `mem_wen` and `mem_addr` are decoded from registered state and pointers).
- With `mem_ready` held high:
  - Dense: the last beat is at t+D and `in_ready` returns at t+D+1.
  - Sparse: the last beat is at t+S and `in_ready` returns at t+S+1.
- Throughput is one vector per D+1 (dense) or S+1 (sparse) cycles. There is no back-to-back acceptance.
- `frame_done` is high during the first IDLE cycle after the final beat.
- Each cycle `mem_ready` is low adds exactly one cycle of latency.

## Test plan
- **Dense vector:** defaults, `base_addr`=0x10, dense vector. Expect `mem_wen` = 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000 over cycles t+1..t+8 and `write_count` = 0..7. Bank 0 addresses are 0x10 then 0x11. `in_ready` is high at t+9.
- **Sparse vector:** sparse vector. Expect `mem_wen` = 1111 at t+1 and t+2, `write_count` = 0,1, all bank addresses 0x10 then 0x11, and `in_ready` high at t+3.
- **Stall:** dense vector with `mem_ready` low at beats 2 and 5. Expect `write_count` and `mem_wen` to hold, the last beat at t+10, and no pointer advance during the stall.
- **Frame completion:** 4 sparse vectors back-to-back. Expect `frame_done` to pulse once, in the cycle after the 8th beat. Bank pointers end at base+8. A 5th vector starts `batch_cnt` again from 0.
- **Overflow and restart:** `base_addr`=0xFF with a sparse vector. Expect pointers 0xFF→0x00 and `err_overflow` to latch. A following `frame_start` asserted together with `in_valid` clears the error and writes from the new base.
- **Reset mid-operation:** assert `rst_n`=0 at dense beat 3. Expect all outputs at their reset values the next cycle, `mem_wen`=0, and `in_ready`=1 after release.
